// File: rtl/mux_nx1_stream_pkg.sv
// Shared constants and helpers for the N-to-1 streaming multiplexer.
package mux_nx1_stream_pkg;

    // Candidate selection modes
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Select width for n channels, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nx1_stream_if.sv
// Handshake bundle between N producers, the multiplexer and one consumer.
// master: the environment (producers + consumer); slave: the multiplexer.
interface mux_nx1_stream_if
    import mux_nx1_stream_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SW = clog2_min1(N);

    logic [N*W-1:0] d;
    logic [N-1:0]   d_valid;
    logic [N-1:0]   d_ready;
    logic [SW-1:0]  sel;
    logic [W-1:0]   y;
    logic           y_valid;
    logic           y_ready;
    logic [SW-1:0]  grant;

    modport master (
        output d, d_valid, sel, y_ready,
        input  d_ready, y, y_valid, grant
    );

    modport slave (
        input  d, d_valid, sel, y_ready,
        output d_ready, y, y_valid, grant
    );

endinterface

// File: rtl/mux_nx1_stream_rr_arbiter.sv
// Combinational round-robin search: picks the first requesting channel
// starting at ptr_i and wrapping modulo N. The pointer itself lives in
// the caller.
module rr_arbiter
    import mux_nx1_stream_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = clog2_min1(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    output logic [SW-1:0] gnt_idx_o,
    output logic          gnt_any_o
);
    localparam logic [SW:0] N_W = (SW+1)'(N);

    logic [SW:0] idx_s;

    // Scan from farthest to nearest so the nearest requester after ptr wins
    always_comb begin
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        idx_s     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx_s = {1'b0, ptr_i} + (SW+1)'(k);
            if (idx_s >= N_W) begin
                idx_s = idx_s - N_W;
            end else begin
                idx_s = idx_s;
            end
            if (req_i[idx_s[SW-1:0]]) begin
                gnt_idx_o = idx_s[SW-1:0];
                gnt_any_o = 1'b1;
            end else begin
                gnt_any_o = gnt_any_o;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_stream.sv
// N-to-1, W-bit registered multiplexer with per-channel valid/ready.
// MODE_FIXED: the select input names the channel; MODE_RR: round-robin
// among valid channels. One output register stage, full throughput.
module mux_nx1_stream
    import mux_nx1_stream_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = MODE_FIXED
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mux_nx1_stream_if.slave bus
);
    localparam int              SW       = clog2_min1(N);
    localparam logic [SW:0]     N_W      = (SW+1)'(N);
    localparam logic [SW-1:0]   LAST_IDX = SW'(N - 1);

    logic [SW-1:0] cand_idx_s;
    logic          cand_any_s;
    logic [W-1:0]  cand_data_s;
    logic          cand_valid_s;
    logic          load_en_s;
    logic          xfer_s;
    logic [N-1:0]  d_ready_s;

    logic [W-1:0]  y_q, y_d;
    logic          y_valid_q, y_valid_d;
    logic [SW-1:0] grant_q, grant_d;

    // Output register is free when empty or being drained this cycle
    assign load_en_s = !y_valid_q | bus.y_ready;
    assign xfer_s    = load_en_s & cand_any_s & cand_valid_s;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SW-1:0] ptr_q, ptr_d;

            rr_arbiter #(.N(N), .SW(SW)) u_arb (
                .req_i     (bus.d_valid),
                .ptr_i     (ptr_q),
                .gnt_idx_o (cand_idx_s),
                .gnt_any_o (cand_any_s)
            );

            // Advance pointer past the channel just served, wrapping at N-1
            always_comb begin
                if (xfer_s) begin
                    if (cand_idx_s == LAST_IDX) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = cand_idx_s + SW'(1);
                    end
                end else begin
                    ptr_d = ptr_q;
                end
            end

            // Round-robin pointer register
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= ptr_d;
                end
            end
        end else begin : g_fixed
            // Select input is the candidate; out-of-range selects offer nothing
            always_comb begin
                cand_idx_s = bus.sel;
                cand_any_s = ({1'b0, bus.sel} < N_W);
            end
        end
    endgenerate

    // Fetch data and valid of the candidate channel
    always_comb begin
        cand_data_s  = '0;
        cand_valid_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cand_idx_s == SW'(i)) begin
                cand_data_s  = bus.d[i*W +: W];
                cand_valid_s = bus.d_valid[i];
            end else begin
                cand_valid_s = cand_valid_s;
            end
        end
    end

    // One-hot ready towards the candidate; silent while reset is held
    always_comb begin
        d_ready_s = '0;
        for (int i = 0; i < N; i++) begin
            if (cand_idx_s == SW'(i)) begin
                d_ready_s[i] = load_en_s & cand_any_s & !rst_i;
            end else begin
                d_ready_s[i] = 1'b0;
            end
        end
    end

    // Next output state: load on transfer, empty on idle load slot, else hold
    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        grant_d   = grant_q;
        if (load_en_s) begin
            if (xfer_s) begin
                y_d       = cand_data_s;
                y_valid_d = 1'b1;
                grant_d   = cand_idx_s;
            end else begin
                y_valid_d = 1'b0;
            end
        end else begin
            y_valid_d = y_valid_q;
        end
    end

    // Output register stage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            grant_q   <= '0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            grant_q   <= grant_d;
        end
    end

    assign bus.d_ready = d_ready_s;
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.grant   = grant_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Directed bench: fixed-select and round-robin N=4 instances plus an N=3
// fixed-select instance for the out-of-range select case.
module tb_mux_nx1_stream;
    import mux_nx1_stream_pkg::*;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   chk_cnt;

    mux_nx1_stream_if #(.N(4), .W(8)) b0 ();
    mux_nx1_stream_if #(.N(4), .W(8)) b1 ();
    mux_nx1_stream_if #(.N(3), .W(8)) b2 ();

    mux_nx1_stream #(.N(4), .W(8), .MODE(MODE_FIXED)) u0 (
        .clk_i (clk), .rst_i (rst), .bus (b0)
    );
    mux_nx1_stream #(.N(4), .W(8), .MODE(MODE_RR)) u1 (
        .clk_i (clk), .rst_i (rst), .bus (b1)
    );
    mux_nx1_stream #(.N(3), .W(8), .MODE(MODE_FIXED)) u2 (
        .clk_i (clk), .rst_i (rst), .bus (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        rst = 1'b1;
        b0.d = '0; b0.d_valid = '0; b0.sel = '0; b0.y_ready = 1'b0;
        b1.d = '0; b1.d_valid = '0; b1.sel = '0; b1.y_ready = 1'b0;
        b2.d = '0; b2.d_valid = '0; b2.sel = '0; b2.y_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y",        b0.y,        32'h0);
        chk("rst_yvalid",   b0.y_valid,  32'h0);
        chk("rst_grant",    b0.grant,    32'h0);
        chk("rst_dready0",  b0.d_ready,  32'h0);
        chk("rst_dready1",  b1.d_ready,  32'h0);
        rst = 1'b0;
        #1;

        // Fixed select, SEL=2, ch2=A5
        b0.sel = 2'd2; b0.d = {8'h00, 8'hA5, 8'h00, 8'h00};
        b0.d_valid = 4'b0100; b0.y_ready = 1'b1;
        #1;
        chk("fix_dready",   b0.d_ready,  32'b0100);
        step();
        chk("fix_y",        b0.y,        32'hA5);
        chk("fix_yvalid",   b0.y_valid,  32'h1);
        chk("fix_grant",    b0.grant,    32'h2);

        // Ready offered to SEL even when that channel is not valid; no transfer
        b0.d_valid = 4'b0000; b0.sel = 2'd1;
        #1;
        chk("fix_rdy_novalid", b0.d_ready, 32'b0010);
        step();
        chk("idle_yvalid",  b0.y_valid,  32'h0);
        chk("idle_y_hold",  b0.y,        32'hA5);
        chk("idle_g_hold",  b0.grant,    32'h2);

        // Back-pressure with Y=3C
        b0.sel = 2'd3; b0.d = {8'h3C, 8'h00, 8'h00, 8'h00}; b0.d_valid = 4'b1000;
        step();
        chk("bp_load_y",    b0.y,        32'h3C);
        chk("bp_load_g",    b0.grant,    32'h3);
        b0.y_ready = 1'b0; b0.sel = 2'd1;
        b0.d = {8'h77, 8'h66, 8'h55, 8'h44}; b0.d_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_dready",  b0.d_ready,  32'h0);
            step();
            chk("bp_y",       b0.y,        32'h3C);
            chk("bp_grant",   b0.grant,    32'h3);
            chk("bp_yvalid",  b0.y_valid,  32'h1);
        end
        // Drain and load on the same edge
        b0.y_ready = 1'b1; b0.sel = 2'd0;
        b0.d = {8'h00, 8'h00, 8'h00, 8'h11}; b0.d_valid = 4'b0001;
        #1;
        chk("drain_dready", b0.d_ready,  32'b0001);
        step();
        chk("drain_y",      b0.y,        32'h11);
        chk("drain_yvalid", b0.y_valid,  32'h1);
        chk("drain_grant",  b0.grant,    32'h0);

        // Round-robin, all channels valid: grants 0,1,2,3,0,1
        b1.d = {8'h44, 8'h33, 8'h22, 8'h11}; b1.d_valid = 4'b1111; b1.y_ready = 1'b1;
        #1;
        chk("rr_dready0",   b1.d_ready,  32'b0001);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_grant",   b1.grant,    32'(i % 4));
            chk("rr_y",       b1.y,        32'(8'h11 * ((i % 4) + 1)));
        end

        // Round-robin, ch1 and ch3 only, pointer now 2
        b1.d_valid = 4'b1010;
        #1;
        chk("rr2_dready_a", b1.d_ready,  32'b1000);
        step();
        chk("rr2_grant_a",  b1.grant,    32'h3);
        chk("rr2_y_a",      b1.y,        32'h44);
        chk("rr2_dready_b", b1.d_ready,  32'b0010);
        step();
        chk("rr2_grant_b",  b1.grant,    32'h1);
        chk("rr2_y_b",      b1.y,        32'h22);
        step();
        chk("rr2_grant_c",  b1.grant,    32'h3);

        // N=3, out-of-range select
        b2.sel = 2'd1; b2.d = {8'h00, 8'h5A, 8'h00}; b2.d_valid = 3'b010; b2.y_ready = 1'b1;
        step();
        chk("n3_y",         b2.y,        32'h5A);
        chk("n3_grant",     b2.grant,    32'h1);
        b2.sel = 2'd3; b2.d_valid = 3'b111;
        #1;
        chk("n3_oor_dready", b2.d_ready, 32'h0);
        step();
        chk("n3_oor_yvalid", b2.y_valid, 32'h0);
        chk("n3_oor_y_hold", b2.y,       32'h5A);
        chk("n3_oor_g_hold", b2.grant,   32'h1);

        // Reset mid-stream while output register is full
        chk("pre_rst_yvalid", b0.y_valid, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_y",      b0.y,       32'h0);
        chk("mid_rst_yvalid", b0.y_valid, 32'h0);
        chk("mid_rst_dready", b0.d_ready, 32'h0);
        chk("mid_rst_rr_yv",  b1.y_valid, 32'h0);
        step();
        rst = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
